// File: rtl/iob_timer_mc.sv
// -----------------------------------------------------------------------------
// iob_timer_mc -- multi-channel compare/match timer on the IOb native bus.
//
// N_CH independent counters share one prescaler. Each channel counts on
// prescaler ticks up to its CMP value, then either reloads to 0 (periodic)
// or stops and clears its own EN (one-shot). Every match sets a sticky
// MATCH flag (write-1-to-clear). irq_o[c] is MATCH (or CAP) AND IRQ_EN.
//
// Optional feature macro: IOB_TIMER_MC_CAPTURE_EN
//   Adds input capture_i[N_CH-1:0]. Each line passes a 2-flop synchronizer.
//   A synchronized rising edge latches CNT into CAPV[c] and sets STATUS.CAP.
//   CAPV[sel] is read at global 0x08, where sel = CTRL[7:4] (RW).
//   Without the macro: no capture_i, STATUS.CAP, 0x08 and CTRL[7:4] read 0.
//
// Register map (byte addresses, bits [1:0] ignored):
//   0x00 CTRL    W bit0 soft reset (self-clearing); [7:4] capture select
//   0x04 PRESC   PRESC_W bits RW
//   0x08 CAPV    capture value of selected channel (capture build only)
//   0x10*(c+1) + 0x0 CFG    bit0 EN, bit1 PERIODIC, bit2 IRQ_EN
//                + 0x4 CMP    CNT_W bits RW
//                + 0x8 CNT    CNT_W bits RW (live)
//                + 0xC STATUS bit0 MATCH, bit1 CAP; write 1 clears
//
// Ports:
//   clk_i, cke_i, arst_i            clock, clock enable, async active-high reset
//   iob_valid_i/addr_i/wdata_i/wstrb_i   request (wstrb != 0 -> write)
//   iob_ready_o (const 1), iob_rvalid_o, iob_rdata_o   response, 1-cycle read
//   irq_o[N_CH]                     per-channel level interrupt
//   capture_i[N_CH]                 capture inputs (capture build only)
// -----------------------------------------------------------------------------

// Per-channel counter, flags and capture register.
module iob_timer_mc_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             cke,
    input  logic             srst,
    input  logic             tick,
    input  logic             wr_cfg,
    input  logic             wr_cmp,
    input  logic             wr_cnt,
    input  logic             wr_sts,
    input  logic [2:0]       wcfg,
    input  logic [CNT_W-1:0] wval,
    input  logic [1:0]       wsts,
    input  logic             cap_evt,
    output logic             en,
    output logic             periodic,
    output logic             irq_en,
    output logic [CNT_W-1:0] cmp,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] capv,
    output logic             match,
    output logic             cap
);

    logic hit;
    assign hit = tick && en && (cnt == cmp);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            en       <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            cmp      <= '0;
            cnt      <= '0;
            capv     <= '0;
            match    <= 1'b0;
            cap      <= 1'b0;
        end else if (cke) begin
            if (srst) begin
                en       <= 1'b0;
                periodic <= 1'b0;
                irq_en   <= 1'b0;
                cmp      <= '0;
                cnt      <= '0;
                capv     <= '0;
                match    <= 1'b0;
                cap      <= 1'b0;
            end else begin
                // Hardware update first; later software writes override it.
                if (tick && en) begin
                    if (cnt == cmp) begin
                        if (periodic) cnt <= '0;
                        else          en  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                if (wr_cnt) cnt <= wval;
                if (wr_cmp) cmp <= wval;
                if (wr_cfg) {irq_en, periodic, en} <= wcfg;
                // W1C first so a same-cycle set wins.
                if (wr_sts && wsts[0]) match <= 1'b0;
                if (hit)               match <= 1'b1;
                if (wr_sts && wsts[1]) cap   <= 1'b0;
                if (cap_evt) begin
                    cap  <= 1'b1;
                    capv <= cnt;
                end
            end
        end
    end

endmodule

module iob_timer_mc #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic [N_CH-1:0]     irq_o
`ifdef IOB_TIMER_MC_CAPTURE_EN
    ,
    input  logic [N_CH-1:0]     capture_i
`endif
);

    localparam int PG_W = ADDR_W - 4;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [PG_W-1:0]   page;
        logic [1:0]        word;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    bus_req_t req;

    always_comb begin
        req.rd    = iob_valid_i && cke_i && (iob_wstrb_i == '0);
        req.wr    = iob_valid_i && cke_i && (iob_wstrb_i != '0);
        req.page  = iob_addr_i[ADDR_W-1:4];
        req.word  = iob_addr_i[3:2];
        req.wdata = iob_wdata_i;
    end

    logic glb_pg, wr_ctrl, wr_presc, srst;
    assign glb_pg   = (req.page == '0);
    assign wr_ctrl  = req.wr && glb_pg && (req.word == 2'd0);
    assign wr_presc = req.wr && glb_pg && (req.word == 2'd1);
    assign srst     = wr_ctrl && req.wdata[0];

    assign iob_ready_o = 1'b1;

    // ---------------- prescaler ----------------
    logic [PRESC_W-1:0] presc_q, pcnt_q;
    logic               tick;
    assign tick = (pcnt_q == presc_q);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else if (cke_i) begin
            if (srst) begin
                presc_q <= '0;
                pcnt_q  <= '0;
            end else if (wr_presc) begin
                presc_q <= req.wdata[PRESC_W-1:0];
                pcnt_q  <= '0;
            end else begin
                pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
            end
        end
    end

    // ---------------- capture synchronizer ----------------
    logic [N_CH-1:0] cap_evt;
`ifdef IOB_TIMER_MC_CAPTURE_EN
    logic [3:0] ctrl_sel;
    // [0],[1] synchronize; [2] is the previous synchronized value for edge
    // detection. Edge in cycle T latches the counter value of T+2.
    logic [2:0][N_CH-1:0] cap_pipe;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cap_pipe <= '0;
            ctrl_sel <= '0;
        end else if (cke_i) begin
            cap_pipe <= {cap_pipe[1], cap_pipe[0], capture_i};
            if (wr_ctrl) ctrl_sel <= req.wdata[7:4];
        end
    end

    assign cap_evt = cap_pipe[1] & ~cap_pipe[2];
`else
    assign cap_evt = '0;
`endif

    // ---------------- channels ----------------
    logic [N_CH-1:0]            en_q, per_q, ien_q, match_q, cap_q;
    logic [N_CH-1:0][CNT_W-1:0] cmp_q, cnt_q, capv_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic ch_wr;
        assign ch_wr = req.wr && (req.page == PG_W'(c + 1));

        iob_timer_mc_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk_i),
            .arst     (arst_i),
            .cke      (cke_i),
            .srst     (srst),
            .tick     (tick),
            .wr_cfg   (ch_wr && (req.word == 2'd0)),
            .wr_cmp   (ch_wr && (req.word == 2'd1)),
            .wr_cnt   (ch_wr && (req.word == 2'd2)),
            .wr_sts   (ch_wr && (req.word == 2'd3)),
            .wcfg     (req.wdata[2:0]),
            .wval     (req.wdata[CNT_W-1:0]),
            .wsts     (req.wdata[1:0]),
            .cap_evt  (cap_evt[c]),
            .en       (en_q[c]),
            .periodic (per_q[c]),
            .irq_en   (ien_q[c]),
            .cmp      (cmp_q[c]),
            .cnt      (cnt_q[c]),
            .capv     (capv_q[c]),
            .match    (match_q[c]),
            .cap      (cap_q[c])
        );
    end

    assign irq_o = (match_q | cap_q) & ien_q;

    // ---------------- read path ----------------
    logic [DATA_W-1:0] rmux;

    always_comb begin
        rmux = '0;
        if (glb_pg) begin
            case (req.word)
`ifdef IOB_TIMER_MC_CAPTURE_EN
                2'd0: rmux[7:4] = ctrl_sel;
                2'd2: begin
                    for (int c = 0; c < N_CH; c++)
                        if (int'(ctrl_sel) == c) rmux[CNT_W-1:0] = capv_q[c];
                end
`endif
                2'd1:    rmux[PRESC_W-1:0] = presc_q;
                default: ;
            endcase
        end
        for (int c = 0; c < N_CH; c++) begin
            if (req.page == PG_W'(c + 1)) begin
                case (req.word)
                    2'd0: rmux[2:0]       = {ien_q[c], per_q[c], en_q[c]};
                    2'd1: rmux[CNT_W-1:0] = cmp_q[c];
                    2'd2: rmux[CNT_W-1:0] = cnt_q[c];
                    2'd3: rmux[1:0]       = {cap_q[c], match_q[c]};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
        end else if (cke_i) begin
            iob_rvalid_o <= req.rd;
            iob_rdata_o  <= req.rd ? rmux : '0;
        end
    end

    // Byte-lane address bits carry no meaning on a word-only bus.
    logic unused_bits;
`ifdef IOB_TIMER_MC_CAPTURE_EN
    assign unused_bits = ^iob_addr_i[1:0];
`else
    assign unused_bits = ^{iob_addr_i[1:0], capv_q};
`endif

endmodule

// File: tb/tb_iob_timer_mc.sv
module tb_iob_timer_mc;
  localparam int N_CH = 4;
  localparam logic [7:0] A_CTRL = 8'h00, A_PRESC = 8'h04, A_CAPV = 8'h08;
  localparam logic [7:0] A_CFG0 = 8'h10, A_CMP0 = 8'h14, A_CNT0 = 8'h18, A_STS0 = 8'h1C;
  localparam logic [7:0] A_CFG1 = 8'h20, A_CMP1 = 8'h24, A_CNT1 = 8'h28, A_STS1 = 8'h2C;
  localparam logic [7:0] A_CFG2 = 8'h30, A_CMP2 = 8'h34, A_CNT2 = 8'h38, A_STS2 = 8'h3C;
  localparam logic [7:0] A_CFG3 = 8'h40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic cke, arst, valid;
  logic [7:0] addr;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic ready, rvalid;
  logic [31:0] rdata;
  logic [N_CH-1:0] irq;
`ifdef IOB_TIMER_MC_CAPTURE_EN
  logic [N_CH-1:0] capture = '0;
`endif

  int n_cmp = 0, n_bad = 0;

  iob_timer_mc #(.N_CH(N_CH)) u_dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_ready_o(ready), .iob_rvalid_o(rvalid), .iob_rdata_o(rdata), .irq_o(irq)
`ifdef IOB_TIMER_MC_CAPTURE_EN
    , .capture_i(capture)
`endif
  );

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    valid = 1'b1; addr = a; wdata = d; wstrb = 4'hF;
    @(posedge clk); #1;
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic v);
    valid = 1'b1; addr = a; wstrb = 4'h0;
    @(posedge clk); #1;
    valid = 1'b0; d = rdata; v = rvalid;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    cke = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0; arst = 1'b1;
    tick_n(3);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if (irq !== 4'h0) begin n_bad++; $display("FAIL reset_irq: got %h want 0", irq); end
    arst = 1'b0;
    tick_n(1);
    begin
      logic [31:0] d; logic v;
      bus_read(A_PRESC, d, v);
      n_cmp++; if (v !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL reset_presc: got v=%b %h want v=1 0", v, d); end
      bus_read(A_CNT0, d, v);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_cnt0: got %h want 0", d); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] d; logic v;
    bus_write(A_PRESC, 32'h0001_2345);
    n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_bad++; $display("FAIL write_no_rvalid: got v=%b %h want v=0 0", rvalid, rdata); end
    bus_read(A_PRESC, d, v);
    n_cmp++; if (d !== 32'h0000_2345) begin n_bad++; $display("FAIL presc_trunc: got %h want 00002345", d); end
    bus_read(8'h0C, d, v);
    n_cmp++; if (v !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL unmapped_0c: got v=%b %h want v=1 0", v, d); end
    bus_write(8'h50, 32'hDEAD_BEEF);
    bus_read(8'h50, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_50: got %h want 0", d); end
    bus_read(A_CAPV, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL capv_idle: got %h want 0", d); end
    bus_write(A_CFG3, 32'hFFFF_FFFE);
    bus_read(A_CFG3, d, v);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL cfg3_trunc: got %h want 6", d); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] d; logic v;
    bus_write(A_CTRL, 32'h1);
    bus_read(A_PRESC, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL srst_presc: got %h want 0", d); end
    bus_read(A_CFG3, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL srst_cfg3: got %h want 0", d); end
    bus_read(A_CTRL, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ctrl_reads0: got %h want 0", d); end
  endtask

  task automatic test_back_to_back();
    bus_write(A_CMP1, 32'hAB);
    bus_write(A_CMP2, 32'hCD);
    valid = 1'b1; wstrb = 4'h0; addr = A_CMP1;
    @(posedge clk); #1;
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'hAB) begin n_bad++; $display("FAIL b2b_first: got v=%b %h want v=1 ab", rvalid, rdata); end
    addr = A_CMP2;
    @(posedge clk); #1;
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'hCD) begin n_bad++; $display("FAIL b2b_second: got v=%b %h want v=1 cd", rvalid, rdata); end
    valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_bad++; $display("FAIL b2b_idle: got v=%b %h want v=0 0", rvalid, rdata); end
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_periodic();
    logic [31:0] d; logic v; int first, second;
    bus_write(A_PRESC, 32'd1);
    bus_write(A_CMP0, 32'd3);
    bus_write(A_CFG0, 32'h7);
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (irq[0]) begin first = i; break; end
    end
    n_cmp++; if (first != 8) begin n_bad++; $display("FAIL periodic_first_irq: got cycle %0d want 8", first); end
    bus_write(A_STS0, 32'h1);
    n_cmp++; if (irq[0] !== 1'b0) begin n_bad++; $display("FAIL periodic_w1c_irq: got %b want 0", irq[0]); end
    bus_read(A_STS0, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL periodic_w1c_sts: got %h want 0", d); end
    second = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (irq[0]) begin second = i; break; end
    end
    n_cmp++; if (second != 6) begin n_bad++; $display("FAIL periodic_second_irq: got cycle %0d want 6", second); end
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_oneshot();
    logic [31:0] d; logic v;
    bus_write(A_CMP1, 32'd5);
    bus_write(A_CFG1, 32'h1);
    tick_n(10);
    bus_read(A_CNT1, d, v);
    n_cmp++; if (d !== 32'd5) begin n_bad++; $display("FAIL oneshot_cnt: got %h want 5", d); end
    bus_read(A_CFG1, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL oneshot_en_clr: got %h want 0", d); end
    bus_read(A_STS1, d, v);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL oneshot_match: got %h want 1", d); end
    n_cmp++; if (irq[1] !== 1'b0) begin n_bad++; $display("FAIL oneshot_irq_masked: got %b want 0", irq[1]); end
    tick_n(3);
    bus_read(A_CNT1, d, v);
    n_cmp++; if (d !== 32'd5) begin n_bad++; $display("FAIL oneshot_frozen: got %h want 5", d); end
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_collision();
    logic [31:0] d; logic v;
    bus_write(A_CMP0, 32'd3);
    bus_write(A_CFG0, 32'h3);
    tick_n(3);
    bus_write(A_STS0, 32'h1);           // lands on the match tick
    bus_read(A_STS0, d, v);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL coll_set_beats_w1c: got %h want 1", d); end
    bus_write(A_STS0, 32'h1);           // no match this cycle
    bus_read(A_STS0, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL coll_plain_w1c: got %h want 0", d); end
    bus_write(A_CNT0, 32'h10);          // lands on a match/reload tick
    bus_read(A_CNT0, d, v);
    n_cmp++; if (d !== 32'h10) begin n_bad++; $display("FAIL coll_cnt_write: got %h want 10", d); end
    bus_write(A_CMP1, 32'd0);
    bus_write(A_CFG1, 32'h1);
    bus_write(A_CFG1, 32'h1);           // same cycle as one-shot auto-clear
    bus_read(A_CFG1, d, v);
    n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL coll_cfg_beats_clr: got %h want 1", d); end
    bus_read(A_CFG1, d, v);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL coll_then_clr: got %h want 0", d); end
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic v; int hit;
    bus_write(A_CMP2, 32'd2);
    bus_write(A_CNT2, 32'hFFFF_FFFE);
    bus_write(A_CFG2, 32'h5);
    hit = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (irq[2]) begin hit = i; break; end
    end
    n_cmp++; if (hit != 5) begin n_bad++; $display("FAIL wrap_irq: got cycle %0d want 5", hit); end
    bus_read(A_CNT2, d, v);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL wrap_cnt: got %h want 2", d); end
    bus_read(A_CFG2, d, v);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL wrap_cfg: got %h want 4", d); end
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_cke();
    logic [31:0] d; logic v;
    bus_write(A_CMP0, 32'd100);
    bus_write(A_CFG0, 32'h1);
    cke = 1'b0;
    valid = 1'b1; addr = A_PRESC; wdata = 32'h7; wstrb = 4'hF;
    tick_n(5);
    valid = 1'b0; wstrb = 4'h0; cke = 1'b1;
    bus_read(A_CNT0, d, v);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL cke_hold: got %h want 0", d); end
    bus_read(A_CNT0, d, v);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL cke_resume: got %h want 1", d); end
    bus_read(A_PRESC, d, v);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL cke_write_ignored: got %h want 0", d); end
    bus_write(A_CTRL, 32'h1);
  endtask

`ifdef IOB_TIMER_MC_CAPTURE_EN
  task automatic test_capture();
    logic [31:0] d; logic v;
    bus_write(A_CMP2, 32'hFFFF);
    bus_write(A_CFG2, 32'h5);
    tick_n(32);                         // CNT2 == 0x20 this cycle
    capture[2] = 1'b1;
    tick_n(1);
    capture[2] = 1'b0;
    tick_n(2);
    bus_read(A_STS2, d, v);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL cap_status: got %h want 2", d); end
    n_cmp++; if (irq[2] !== 1'b1) begin n_bad++; $display("FAIL cap_irq: got %b want 1", irq[2]); end
    bus_write(A_CTRL, 32'h20);
    bus_read(A_CAPV, d, v);
    n_cmp++; if (d !== 32'h22) begin n_bad++; $display("FAIL cap_value: got %h want 22", d); end
    bus_write(A_STS2, 32'h2);
    n_cmp++; if (irq[2] !== 1'b0) begin n_bad++; $display("FAIL cap_w1c_irq: got %b want 0", irq[2]); end
    bus_write(A_CTRL, 32'h1);
  endtask
`endif

  task automatic test_arst_midrun();
    logic [31:0] d; logic v;
    bus_write(A_CMP0, 32'd1);
    bus_write(A_CFG0, 32'h7);
    tick_n(5);
    n_cmp++; if (irq[0] !== 1'b1) begin n_bad++; $display("FAIL arst_pre_irq: got %b want 1", irq[0]); end
    valid = 1'b1; addr = A_PRESC; wstrb = 4'h0;
    #3 arst = 1'b1;
    #1;
    n_cmp++; if (irq !== 4'h0 || rvalid !== 1'b0 || rdata !== 32'h0) begin n_bad++; $display("FAIL arst_immediate: got irq=%h v=%b %h want 0 0 0", irq, rvalid, rdata); end
    valid = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL arst_no_rvalid: got %b want 0", rvalid); end
    bus_read(A_CFG0, d, v);
    n_cmp++; if (v !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL arst_cfg0: got v=%b %h want v=1 0", v, d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_soft_reset();
    test_back_to_back();
    test_periodic();
    test_oneshot();
    test_collision();
    test_wrap();
    test_cke();
`ifdef IOB_TIMER_MC_CAPTURE_EN
    test_capture();
`endif
    test_arst_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
